switch_control: RTL and testbench

- Central allocator of the 5-port mesh router.
- Input buffers raise a header request. The block picks one requester round-robin, computes its output port with XY routing, grants it if that output is free, and holds the crossbar connection tables until the input buffer reports end of packet.
- It configures the crossbar muxes and the credit-return steering. It sits between the five input buffers and the crossbar.

---
 rtl/dut_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/switch_control.sv | 152 +++++++++++++++
 tb/tb_switch_control.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// Shared types, sizes and the XY routing rule for the mesh router allocator.
package dut_pkg;

  localparam int unsigned NPORT      = 5;
  localparam int unsigned FLIT_WIDTH = 16;
  localparam int unsigned HALF_WIDTH = FLIT_WIDTH / 2;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ROUTE,
    GRANT
  } sw_state_t;

  // Dimension-ordered routing: resolve X first, then Y; equal in both means deliver locally.
  function automatic port_t xy_route(input logic [FLIT_WIDTH-1:0] header,
                                     input logic [FLIT_WIDTH-1:0] router_addr);
    logic [HALF_WIDTH-1:0] tx, ty, lx, ly;
    tx = header[FLIT_WIDTH-1:HALF_WIDTH];
    ty = header[HALF_WIDTH-1:0];
    lx = router_addr[FLIT_WIDTH-1:HALF_WIDTH];
    ly = router_addr[HALF_WIDTH-1:0];
    if (tx > lx)      return EAST;
    else if (tx < lx) return WEST;
    else if (ty > ly) return NORTH;
    else if (ty < ly) return SOUTH;
    else              return LOCAL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping at N-1.
module rr_arbiter #(
  parameter  int unsigned N  = 5,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int unsigned cand;

  // Scan offsets 1..N from the pointer so the last winner has lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/switch_control.sv
// Switch allocator: round-robin selects a header, XY-routes it, grants a free
// output and holds the crossbar/credit tables until the packet finishes.
module switch_control
  import dut_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [FLIT_WIDTH-1:0]       router_addr,
  input  logic [NPORT-1:0]            h,
  input  logic [NPORT*FLIT_WIDTH-1:0] header_i,
  input  logic [NPORT-1:0]            pkt_done,
  output logic [NPORT-1:0]            ack_h,
  output logic [NPORT-1:0]            in_active,
  output logic [NPORT-1:0]            out_busy,
  output logic [NPORT*3-1:0]          in_sel,
  output logic [NPORT*3-1:0]          out_sel
);

  sw_state_t             state, state_n;
  logic [2:0]            rr;
  logic [2:0]            sel;
  logic [NPORT-1:0]      sel_oh;
  port_t                 dest;

  logic [NPORT-1:0]      req;
  logic [NPORT-1:0]      arb_grant;
  logic [2:0]            arb_idx;
  logic                  arb_valid;

  logic [FLIT_WIDTH-1:0] hdr_sel;
  port_t                 route_dest;
  logic                  route_blocked;

  logic [NPORT-1:0]      rel_in;
  logic [NPORT-1:0]      rel_out;
  logic [NPORT-1:0]      active_n;
  logic [NPORT-1:0]      busy_n;

  logic [2:0]            in_sel_q  [NPORT];
  port_t                 out_sel_q [NPORT];

  // Inputs that already own a connection cannot request again.
  assign req = h & ~in_active;

  rr_arbiter #(.N(NPORT)) u_arb (
    .req   (req),
    .ptr   (rr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Header of the currently selected input and its XY destination.
  always_comb begin
    hdr_sel = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (sel == 3'(p)) hdr_sel = header_i[p*FLIT_WIDTH +: FLIT_WIDTH];
    end
    route_dest = xy_route(hdr_sel, router_addr);
  end

  // Outputs freed this cycle by end-of-packet pulses from active inputs.
  always_comb begin
    rel_in  = pkt_done & in_active;
    rel_out = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (rel_in[i]) rel_out[out_sel_q[i]] = 1'b1;
    end
    route_blocked = out_busy[route_dest] | rel_out[route_dest];
  end

  // Next-state decode for the allocation loop.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|req) state_n = ARB;
      ARB:     state_n = arb_valid ? ROUTE : IDLE;
      ROUTE:   state_n = route_blocked ? IDLE : GRANT;
      GRANT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant pulse is a pure decode of the GRANT state.
  always_comb begin
    ack_h = '0;
    if (state == GRANT) ack_h = sel_oh;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Arbitration pointer, selected input and routed destination.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr     <= 3'(LOCAL);
      sel    <= '0;
      sel_oh <= '0;
      dest   <= EAST;
    end else begin
      if (state == ARB && arb_valid) begin
        rr     <= arb_idx;
        sel    <= arb_idx;
        sel_oh <= arb_grant;
      end
      if (state == ROUTE && !route_blocked) dest <= route_dest;
    end
  end

  // Releases and the new grant are merged so both land on the same edge.
  always_comb begin
    active_n = in_active & ~rel_in;
    busy_n   = out_busy & ~rel_out;
    if (state == GRANT) begin
      active_n[sel]  = 1'b1;
      busy_n[dest]   = 1'b1;
    end
  end

  // Connection tables.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_active <= '0;
      out_busy  <= '0;
      for (int unsigned p = 0; p < NPORT; p++) begin
        in_sel_q[p]  <= '0;
        out_sel_q[p] <= EAST;
      end
    end else begin
      in_active <= active_n;
      out_busy  <= busy_n;
      if (state == GRANT) begin
        in_sel_q[dest] <= sel;
        out_sel_q[sel] <= dest;
      end
    end
  end

  // Flatten the per-port tables onto the output buses.
  always_comb begin
    in_sel  = '0;
    out_sel = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      in_sel[p*3 +: 3]  = in_sel_q[p];
      out_sel[p*3 +: 3] = out_sel_q[p];
    end
  end

endmodule

// File: tb/tb_switch_control.sv
// Directed and randomized checks of switch_control against a transaction-level model.
module tb_switch_control;
  import dut_pkg::*;

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  logic [FLIT_WIDTH-1:0]       router_addr;
  logic [NPORT-1:0]            h;
  logic [NPORT*FLIT_WIDTH-1:0] header_i;
  logic [NPORT-1:0]            pkt_done;
  logic [NPORT-1:0]            ack_h;
  logic [NPORT-1:0]            in_active;
  logic [NPORT-1:0]            out_busy;
  logic [NPORT*3-1:0]          in_sel;
  logic [NPORT*3-1:0]          out_sel;

  switch_control dut (
    .clock       (clock),
    .reset       (reset),
    .router_addr (router_addr),
    .h           (h),
    .header_i    (header_i),
    .pkt_done    (pkt_done),
    .ack_h       (ack_h),
    .in_active   (in_active),
    .out_busy    (out_busy),
    .in_sel      (in_sel),
    .out_sel     (out_sel)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: owner[o] = input holding output o (-1 free); dest_of[i] = output of input i.
  int               owner   [NPORT];
  int               dest_of [NPORT];
  bit               act     [NPORT];
  int               m_rr;
  logic [15:0]      hdr     [NPORT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_hdr(input int i, input logic [15:0] v);
    hdr[i] = v;
    header_i[i*16 +: 16] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPORT; i++) begin
      owner[i] = -1;
      dest_of[i] = 0;
      act[i] = 1'b0;
    end
    m_rr = 4;
  endtask

  task automatic model_grant(input int i);
    int d;
    d = int'(xy_route(hdr[i], router_addr));
    owner[d] = i;
    dest_of[i] = d;
    act[i] = 1'b1;
    m_rr = i;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    h = '0;
    pkt_done = '0;
    tick();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_tables(input string tag);
    logic [4:0] eb, ea;
    eb = '0;
    ea = '0;
    for (int i = 0; i < NPORT; i++) begin
      ea[i] = act[i];
      eb[i] = (owner[i] >= 0);
    end
    chk({tag, ".out_busy"}, 32'(out_busy), 32'(eb));
    chk({tag, ".in_active"}, 32'(in_active), 32'(ea));
    for (int o = 0; o < NPORT; o++)
      if (owner[o] >= 0) chk({tag, ".in_sel"}, 32'(in_sel[o*3 +: 3]), 32'(owner[o]));
    for (int i = 0; i < NPORT; i++)
      if (act[i]) chk({tag, ".out_sel"}, 32'(out_sel[i*3 +: 3]), 32'(dest_of[i]));
  endtask

  task automatic wait_ack(input int limit, output logic [4:0] a, output int cyc);
    a = '0;
    cyc = 0;
    for (int c = 1; c <= limit; c++) begin
      tick();
      cyc = c;
      if (ack_h !== 5'b0) break;
    end
    a = ack_h;
  endtask

  // Transaction-level prediction: repeated round-robin attempts until one finds a free output.
  task automatic predict(input logic [4:0] hv, output int exp_i);
    logic [4:0] elig;
    int r, found, d;
    exp_i = -1;
    r = m_rr;
    for (int i = 0; i < NPORT; i++) elig[i] = hv[i] & ~act[i];
    for (int attempt = 0; attempt < NPORT; attempt++) begin
      found = -1;
      for (int off = 1; off <= NPORT; off++) begin
        if (found < 0 && elig[(r + off) % NPORT]) found = (r + off) % NPORT;
      end
      if (found < 0) break;
      r = found;
      d = int'(xy_route(hdr[found], router_addr));
      if (owner[d] < 0) begin
        exp_i = found;
        break;
      end
    end
  endtask

  function automatic logic [15:0] rand_hdr(input logic [15:0] ra);
    logic [7:0] tx, ty;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    tx = ra[15:8] + 8'($urandom_range(0, 2)) - 8'd1;
    ty = ra[7:0]  + 8'($urandom_range(0, 2)) - 8'd1;
    return {tx, ty};
  endfunction

  initial begin
    logic [4:0] a, seen, pd, hv;
    int cyc, exp_i;
    string tg;

    h = '0;
    pkt_done = '0;
    header_i = '0;
    router_addr = 16'h0101;
    for (int i = 0; i < NPORT; i++) hdr[i] = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    chk("rst.ack_h", 32'(ack_h), 32'h0);
    chk("rst.in_active", 32'(in_active), 32'h0);
    chk("rst.out_busy", 32'(out_busy), 32'h0);
    chk("rst.in_sel", 32'(in_sel), 32'h0);
    chk("rst.out_sel", 32'(out_sel), 32'h0);

    // Single grant: LOCAL input to EAST, exact latency
    set_hdr(4, 16'h0201);
    h = 5'b10000;
    tick(); chk("t1.ack_k1", 32'(ack_h), 32'h0);
    tick(); chk("t1.ack_k2", 32'(ack_h), 32'h0);
    tick(); chk("t1.ack_k3", 32'(ack_h), 32'b10000);
    h = '0;
    tick(); chk("t1.ack_k4", 32'(ack_h), 32'h0);
    chk("t1.out_busy", 32'(out_busy), 32'b00001);
    chk("t1.in_sel_e", 32'(in_sel[2:0]), 32'd4);
    chk("t1.out_sel_l", 32'(out_sel[14:12]), 32'd0);
    chk("t1.in_active", 32'(in_active), 32'b10000);
    pkt_done = 5'b10000;
    tick();
    pkt_done = '0;
    chk("t1.rel_busy", 32'(out_busy), 32'h0);
    chk("t1.rel_active", 32'(in_active), 32'h0);

    // Contention on LOCAL: WEST first, NORTH waits for release
    set_hdr(1, 16'h0101);
    set_hdr(2, 16'h0101);
    h = 5'b00110;
    wait_ack(10, a, cyc);
    chk("t2.first", 32'(a), 32'b00010);
    h = 5'b00100;
    tick();
    chk("t2.busy", 32'(out_busy), 32'b10000);
    seen = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen |= ack_h;
    end
    chk("t2.blocked", 32'(seen), 32'h0);
    pkt_done = 5'b00010;
    tick();
    pkt_done = '0;
    wait_ack(10, a, cyc);
    chk("t2.second", 32'(a), 32'b00100);
    chk("t2.within8", 32'(cyc <= 7), 32'd1);
    h = '0;
    tick();
    chk("t2.in_sel_l", 32'(in_sel[14:12]), 32'd2);
    chk("t2.in_active", 32'(in_active), 32'b00100);
    pkt_done = 5'b00100;
    tick();
    pkt_done = '0;

    // Fairness: five requesters, five distinct outputs
    pulse_reset();
    set_hdr(0, 16'h0201);
    set_hdr(1, 16'h0001);
    set_hdr(2, 16'h0102);
    set_hdr(3, 16'h0100);
    set_hdr(4, 16'h0101);
    h = 5'b11111;
    wait_ack(10, a, cyc);
    chk("t3.g0", 32'(a), 32'b00001);
    chk("t3.lat", 32'(cyc), 32'd3);
    for (int g = 1; g < NPORT; g++) begin
      seen = '0;
      for (int c = 0; c < 3; c++) begin
        tick();
        seen |= ack_h;
      end
      chk("t3.gap", 32'(seen), 32'h0);
      tick();
      chk("t3.gn", 32'(ack_h), 32'(5'b1 << g));
    end
    tick();
    chk("t3.all_active", 32'(in_active), 32'b11111);
    chk("t3.all_busy", 32'(out_busy), 32'b11111);
    for (int o = 0; o < NPORT; o++) chk("t3.in_sel", 32'(in_sel[o*3 +: 3]), 32'(o));
    h = '0;

    // Async reset in the middle of a grant
    pulse_reset();
    h = 5'b11111;
    wait_ack(10, a, cyc);
    chk("t5.g0", 32'(a), 32'b00001);
    for (int c = 0; c < 4; c++) tick();
    chk("t5.g1", 32'(ack_h), 32'b00010);
    chk("t5.pre_busy", 32'(out_busy), 32'b00001);
    #2 reset = 1'b0;
    #1;
    chk("t5.ack", 32'(ack_h), 32'h0);
    chk("t5.busy", 32'(out_busy), 32'h0);
    chk("t5.active", 32'(in_active), 32'h0);
    tick();
    reset = 1'b1;
    model_reset();
    wait_ack(10, a, cyc);
    chk("t5.after", 32'(a), 32'b00001);
    model_grant(0);
    h = '0;
    tick();
    check_tables("t5");

    // Spurious end-of-packet on an idle input
    pkt_done = 5'b01000;
    tick();
    pkt_done = '0;
    tick();
    check_tables("t6");

    // Release racing a ROUTE for the same output
    pulse_reset();
    set_hdr(4, 16'h0201);
    h = 5'b10000;
    wait_ack(10, a, cyc);
    chk("t4.owner", 32'(a), 32'b10000);
    h = '0;
    tick();
    set_hdr(0, 16'h0201);
    h = 5'b00001;
    tick();
    tick();
    pkt_done = 5'b10000;
    tick();
    pkt_done = '0;
    chk("t4.no_ack", 32'(ack_h), 32'h0);
    chk("t4.released", 32'(out_busy), 32'h0);
    wait_ack(8, a, cyc);
    chk("t4.retry", 32'(a), 32'b00001);
    chk("t4.retry_lat", 32'(cyc), 32'd3);
    h = '0;
    tick();
    chk("t4.busy", 32'(out_busy), 32'b00001);
    chk("t4.in_sel_e", 32'(in_sel[2:0]), 32'd0);
    chk("t4.active", 32'(in_active), 32'b00001);

    // Randomized rounds against the model
    reset = 1'b0;
    router_addr = {8'($urandom_range(2, 253)), 8'($urandom_range(2, 253))};
    tick();
    reset = 1'b1;
    model_reset();
    for (int rnd = 0; rnd < 40; rnd++) begin
      pd = 5'($urandom);
      pkt_done = pd;
      for (int i = 0; i < NPORT; i++) begin
        if (pd[i] && act[i]) begin
          owner[dest_of[i]] = -1;
          act[i] = 1'b0;
        end
      end
      tick();
      pkt_done = '0;
      check_tables("rnd.rel");
      for (int i = 0; i < NPORT; i++) set_hdr(i, rand_hdr(router_addr));
      hv = 5'($urandom);
      predict(hv, exp_i);
      h = hv;
      if (exp_i >= 0) begin
        wait_ack(40, a, cyc);
        tg = $sformatf("rnd%0d.ack", rnd);
        chk(tg, 32'(a), 32'(5'b1 << exp_i));
        model_grant(exp_i);
        h = '0;
        tick();
        chk("rnd.ack_clear", 32'(ack_h), 32'h0);
        check_tables("rnd.grant");
      end else begin
        wait_ack(40, a, cyc);
        chk("rnd.no_grant", 32'(a), 32'h0);
        pulse_reset();
        check_tables("rnd.reset");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
